neuron_mac: RTL and testbench
=============================

Name: neuron_mac

Overview:
Single-neuron multiply-accumulate engine that sits directly downstream of the weight ROM. On each start it drives that ROM's address and read-enable to fetch N_INPUTS weights plus one bias word. It multiplies each weight by an activation taken from an input valid/ready stream and accumulates the products. It then adds the bias, rescales, saturates, optionally applies ReLU, and presents one output word on a valid/ready stream.

Parameters:
ADDR_WIDTH, 8, width of ROM address; matches ROM.
DATA_WIDTH, 16, signed fixed-point width of weights, activations and result.
FRAC_BITS, 8, fractional bits of the DATA_WIDTH format (Q8.8 at defaults).
N_INPUTS, 8, activations and weights per neuron; range 1..256.
ACC_WIDTH, 40, signed accumulator width.
BASE_ADDR, 0, ROM address of weight 0. Weight i is at BASE_ADDR+i; bias is at BASE_ADDR+N_INPUTS.
RELU, 1, 1 = clamp negative results to 0; 0 = pass signed result.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse that begins a neuron evaluation; ignored unless idle.
busy  out  1  high in every state except IDLE.
w_addr  out  ADDR_WIDTH  ROM read address.
w_r_en  out  1  ROM read enable.
w_data  in  DATA_WIDTH  ROM read data; valid the cycle after w_r_en, held until the next w_r_en.
x_data  in  DATA_WIDTH  signed activation.
x_valid  in  1  activation valid.
x_ready  out  1  activation accepted when x_valid && x_ready.
y_data  out  DATA_WIDTH  signed neuron result.
y_valid  out  1  result valid; held until accepted.
y_ready  in  1  downstream accept.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE; idx=0; acc=0.
  - busy, w_r_en, x_ready, y_valid = 0; w_addr=0; y_data=0.
  - Reset mid-operation discards the partial accumulation; no output is produced.
- FSM states: IDLE, FETCH, MAC, BFETCH, BIAS, OUT.
- IDLE: on start, clear acc and idx, then go to FETCH.
- FETCH: w_r_en=1 and w_addr=BASE_ADDR+idx for exactly one cycle, then go to MAC. w_r_en is 0 in every other state; w_addr holds its last value.
- MAC:
  - x_ready=1; w_data is valid and stable.
  - On handshake: acc += sign-extend(x_data*w_data). The product is 2*DATA_WIDTH signed.
  - If idx==N_INPUTS-1, go to BFETCH; otherwise idx++ and go to FETCH.
  - Without x_valid, stay in MAC indefinitely.
  - Throughput: at most one activation per 2 cycles.
- BFETCH: w_r_en=1, w_addr=BASE_ADDR+N_INPUTS, go to BIAS.
- BIAS:
  - acc += sign-extend(w_data) << FRAC_BITS, then go to OUT.
  - y_data is computed from the updated acc and registered at the same edge:
    - r = acc >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
    - Saturate r to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
    - If RELU=1 and r<0, r=0.
- OUT: y_valid=1; y_data stable until y_valid && y_ready, then go to IDLE (y_valid=0 next cycle).
- x_ready=0 outside MAC; x_valid in those states is not consumed.
- start outside IDLE is ignored. start in the same cycle that OUT completes is ignored; a new start must arrive when IDLE.
- Accumulator wraps modulo 2^ACC_WIDTH; no overflow flag. Defaults cannot overflow for N_INPUTS <= 256.
- Latency from start: 1 + 2*N_INPUTS + 2 cycles to y_valid when x_valid is held high (19 at defaults).

Decomposition:
- Shared package nn_pkg holds:
  - Q-format constants DATA_WIDTH and FRAC_BITS.
  - Functions sat_to_data(acc) and relu(x).
  - The state enum neuron_state_t.
- One natural sub-module: mac_unit, a combinational signed multiply plus registered accumulate with a clear input. Keep the FSM in neuron_mac.

Test Plan:
- Basic sum: N_INPUTS=4, BASE_ADDR=0; ROM words 0x0100, 0x0200, 0xFF00, 0x0080, bias 0x0080; x=0x0100 x4, x_valid held, y_ready=1 -> y_data=0x0300, y_valid 11 cycles after start, one-cycle pulse.
- Negative result: weights 0xFF00 x4, bias 0, x=0x0100 -> RELU=1 gives y_data=0x0000; RELU=0 gives y_data=0xFC00.
- Saturation: weights 0x7FFF, x=0x7FFF x4, bias 0x7FFF -> y_data=0x7FFF. Negating the weights (0x8001, bias 0x8000) with RELU=0 -> y_data=0x8000.
- Address and back-pressure sequence:
  - BASE_ADDR=0x10: w_r_en pulses exactly 5 times at addresses 0x10, 0x11, 0x12, 0x13, 0x14, each for one cycle.
  - Random x_valid gaps: no extra reads, result unchanged.
  - y_ready low for 5 cycles: y_valid and y_data held stable; start pulses in that window ignored.
- Reset mid-MAC: drive rst low after 2 activations -> outputs 0 within the reset cycle without waiting for a clock edge, no y_valid. A subsequent start with the basic-sum stimulus yields 0x0300.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared Q-format constants, FSM state type and result-conditioning helpers
// for the neuron multiply-accumulate engine.
package nn_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FRAC_BITS  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MAC,
        S_BFETCH,
        S_BIAS,
        S_OUT
    } neuron_state_t;

    // Clamp a wide signed value to the signed range of a dw-bit word.
    function automatic logic signed [63:0] sat_to_data(input logic signed [63:0] v,
                                                       input int unsigned        dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

    function automatic logic signed [63:0] relu(input logic signed [63:0] v);
        return (v < 0) ? 64'sd0 : v;
    endfunction

endpackage

// File: rtl/neuron_mac_mac_unit.sv
// Signed multiply feeding a registered accumulator; also adds a bias word
// aligned to the product's fixed-point scale.
module mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         mul_en,
    input  logic                         bias_en,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc_next
);

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic signed [ACC_WIDTH-1:0]    acc_d;

    assign prod     = a * b;
    assign acc_next = acc_d;

    // NOTE: assign a default before any branch so no path leaves acc_d
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (mul_en) begin
            acc_d = acc_q + ACC_WIDTH'(prod);
        end else if (bias_en) begin
            acc_d = acc_q + (ACC_WIDTH'(b) <<< FRAC_BITS);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Single-neuron engine: fetches weights and bias from the weight ROM, MACs
// them against a streamed activation vector and emits one conditioned result.
module neuron_mac #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = nn_pkg::DATA_WIDTH,
    parameter int FRAC_BITS  = nn_pkg::FRAC_BITS,
    parameter int N_INPUTS   = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int BASE_ADDR  = 0,
    parameter int RELU       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic                  w_r_en,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [DATA_WIDTH-1:0] x_data,
    input  logic                  x_valid,
    output logic                  x_ready,
    output logic [DATA_WIDTH-1:0] y_data,
    output logic                  y_valid,
    input  logic                  y_ready
);

    import nn_pkg::*;

    localparam int IDX_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    neuron_state_t               state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]       w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0]       y_data_q, y_data_d;
    logic                        acc_clear, acc_mul_en, acc_bias_en;
    logic signed [ACC_WIDTH-1:0] acc_next;
    logic signed [63:0]          scaled, saturated, result;

    mac_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clear   (acc_clear),
        .mul_en  (acc_mul_en),
        .bias_en (acc_bias_en),
        .a       (signed'(x_data)),
        .b       (signed'(w_data)),
        .acc_next(acc_next)
    );

    // Result is taken from the accumulator value that includes the bias.
    assign scaled    = 64'(acc_next) >>> FRAC_BITS;
    assign saturated = sat_to_data(scaled, DATA_WIDTH);
    assign result    = (RELU != 0) ? relu(saturated) : saturated;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        w_addr_d    = w_addr_q;
        y_data_d    = y_data_q;
        acc_clear   = 1'b0;
        acc_mul_en  = 1'b0;
        acc_bias_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_clear = 1'b1;
                    idx_d     = '0;
                    w_addr_d  = ADDR_WIDTH'(BASE_ADDR);
                    state_d   = S_FETCH;
                end
            end
            S_FETCH:  state_d = S_MAC;
            S_MAC: begin
                if (x_valid) begin
                    acc_mul_en = 1'b1;
                    if (idx_q == IDX_W'(N_INPUTS - 1)) begin
                        w_addr_d = ADDR_WIDTH'(BASE_ADDR + N_INPUTS);
                        state_d  = S_BFETCH;
                    end else begin
                        idx_d    = idx_q + 1'b1;
                        w_addr_d = ADDR_WIDTH'(BASE_ADDR + int'(idx_q) + 1);
                        state_d  = S_FETCH;
                    end
                end
            end
            S_BFETCH: state_d = S_BIAS;
            S_BIAS: begin
                acc_bias_en = 1'b1;
                y_data_d    = DATA_WIDTH'(result);
                state_d     = S_OUT;
            end
            S_OUT: begin
                if (y_ready) begin
                    state_d = S_IDLE;
                end
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            w_addr_q <= '0;
            y_data_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            w_addr_q <= w_addr_d;
            y_data_q <= y_data_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign w_r_en  = (state_q == S_FETCH) || (state_q == S_BFETCH);
    assign x_ready = (state_q == S_MAC);
    assign y_valid = (state_q == S_OUT);
    assign w_addr  = w_addr_q;
    assign y_data  = y_data_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench: two neuron_mac instances (RELU on at base 0x10, RELU off
// at base 0) share one activation stream and are checked against hand values.
module tb_neuron_mac;

    typedef logic [15:0] vec4_t [4];

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x_data = '0;
    logic        x_valid = 1'b0;
    logic        y_ready = 1'b1;

    logic        busy_a, w_r_en_a, x_ready_a, y_valid_a;
    logic [7:0]  w_addr_a;
    logic [15:0] y_data_a;
    logic [15:0] w_data_a = '0;
    logic        busy_b, w_r_en_b, x_ready_b, y_valid_b;
    logic [7:0]  w_addr_b;
    logic [15:0] y_data_b;
    logic [15:0] w_data_b = '0;

    logic [15:0] rom_a [256];
    logic [15:0] rom_b [256];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    bit          lat_check = 1'b0;
    bit          prev_hs = 1'b0;
    bit          prev_vld = 1'b0;
    logic [15:0] exp_a [$];
    logic [15:0] exp_b [$];
    logic [7:0]  addr_log [$];

    neuron_mac #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .FRAC_BITS(8), .N_INPUTS(4),
        .ACC_WIDTH(40), .BASE_ADDR(16), .RELU(1)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy_a),
        .w_addr(w_addr_a), .w_r_en(w_r_en_a), .w_data(w_data_a),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_a),
        .y_data(y_data_a), .y_valid(y_valid_a), .y_ready(y_ready)
    );

    neuron_mac #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .FRAC_BITS(8), .N_INPUTS(4),
        .ACC_WIDTH(40), .BASE_ADDR(0), .RELU(0)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b),
        .w_addr(w_addr_b), .w_r_en(w_r_en_b), .w_data(w_data_b),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready_b),
        .y_data(y_data_b), .y_valid(y_valid_b), .y_ready(y_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_r_en_a) w_data_a <= rom_a[w_addr_a];
        if (w_r_en_b) w_data_b <= rom_b[w_addr_b];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: read-address log, latency, one-cycle y_valid, scoreboard pops.
    always @(negedge clk) begin
        if (rst) begin
            if (w_r_en_a) addr_log.push_back(w_addr_a);
            if (prev_hs) check("y_valid_pulse", 32'(y_valid_a), 32'd0);
            if (y_valid_a && !prev_vld && lat_check) check("latency", 32'(cyc - start_cyc), 32'd11);
            prev_vld = y_valid_a;
            prev_hs  = y_valid_a && y_ready;
            if (y_valid_a && y_ready) begin
                if (exp_a.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL y_unexpected_a: got 0x%0h, expected no output", y_data_a);
                end else begin
                    check("y_data_a", 32'(y_data_a), 32'(exp_a.pop_front()));
                end
            end
            if (y_valid_b && y_ready) begin
                if (exp_b.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL y_unexpected_b: got 0x%0h, expected no output", y_data_b);
                end else begin
                    check("y_data_b", 32'(y_data_b), 32'(exp_b.pop_front()));
                end
            end
        end else begin
            prev_hs  = 1'b0;
            prev_vld = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input vec4_t w, input logic [15:0] bias);
        for (int i = 0; i < 4; i++) begin
            rom_a[16+i] = w[i];
            rom_b[i]    = w[i];
        end
        rom_a[20] = bias;
        rom_b[4]  = bias;
    endtask

    task automatic pulse_start();
        start     = 1'b1;
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic send_x(input logic [15:0] v, input int gap);
        bit ok = 1'b0;
        repeat (gap) tick();
        x_data  = v;
        x_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (x_ready_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("x_handshake_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic eval(input vec4_t w, input logic [15:0] bias, input vec4_t x,
                        input logic [15:0] ea, input logic [15:0] eb,
                        input int max_gap, input bit lat);
        load(w, bias);
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        lat_check = lat;
        addr_log.delete();
        pulse_start();
        for (int i = 0; i < 4; i++)
            send_x(x[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (exp_a.size() == 0 && exp_b.size() == 0) break;
            tick();
        end
        check("drain_pending", 32'(exp_a.size() + exp_b.size()), 32'd0);
    endtask

    task automatic check_addrs();
        check("rd_count", 32'(addr_log.size()), 32'd5);
        for (int i = 0; i < addr_log.size() && i < 5; i++)
            check("rd_addr", 32'(addr_log[i]), 32'(16 + i));
    endtask

    vec4_t w_basic = '{16'h0100, 16'h0200, 16'hFF00, 16'h0080};
    vec4_t w_neg   = '{16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00};
    vec4_t w_pmax  = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vec4_t w_nmax  = '{16'h8001, 16'h8001, 16'h8001, 16'h8001};
    vec4_t x_one   = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    vec4_t x_max   = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ok;
        repeat (3) tick();
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_w_r_en", 32'(w_r_en_a), 32'd0);
        check("rst_x_ready", 32'(x_ready_a), 32'd0);
        check("rst_y_valid", 32'(y_valid_a), 32'd0);
        check("rst_y_data", 32'(y_data_a), 32'd0);
        rst = 1'b1;
        tick();

        eval(w_basic, 16'h0080, x_one, 16'h0300, 16'h0300, 0, 1'b1);
        drain();
        check_addrs();
        eval(w_neg, 16'h0000, x_one, 16'h0000, 16'hFC00, 0, 1'b1);
        drain();
        eval(w_pmax, 16'h7FFF, x_max, 16'h7FFF, 16'h7FFF, 0, 1'b1);
        drain();
        eval(w_nmax, 16'h8000, x_max, 16'h0000, 16'h8000, 0, 1'b1);
        drain();
        eval(w_basic, 16'h0080, x_one, 16'h0300, 16'h0300, 3, 1'b0);
        drain();
        check_addrs();

        // Back-pressure window with start pulses that must be ignored.
        y_ready = 1'b0;
        eval(w_basic, 16'h0080, x_one, 16'h0300, 16'h0300, 0, 1'b1);
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (y_valid_a) begin
                ok = 1'b1;
                break;
            end
        end
        check("y_valid_seen", 32'(ok), 32'd1);
        check_addrs();
        addr_log.delete();
        @(posedge clk);
        #1;
        start = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("hold_valid", 32'(y_valid_a), 32'd1);
            check("hold_data", 32'(y_data_a), 32'h0300);
            @(posedge clk);
            #1;
        end
        y_ready = 1'b1;
        tick();
        start = 1'b0;
        drain();
        repeat (3) tick();
        check("start_ignored_busy", 32'(busy_a), 32'd0);
        check("start_ignored_reads", 32'(addr_log.size()), 32'd0);

        // Reset in the middle of an evaluation, then a clean rerun.
        load(w_basic, 16'h0080);
        lat_check = 1'b0;
        pulse_start();
        send_x(16'h0100, 0);
        send_x(16'h0100, 0);
        x_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_w_r_en", 32'(w_r_en_a), 32'd0);
        check("arst_x_ready", 32'(x_ready_a), 32'd0);
        check("arst_y_valid", 32'(y_valid_a), 32'd0);
        check("arst_w_addr", 32'(w_addr_a), 32'd0);
        check("arst_y_data", 32'(y_data_a), 32'd0);
        check("arst_busy_b", 32'(busy_b), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        eval(w_basic, 16'h0080, x_one, 16'h0300, 16'h0300, 0, 1'b1);
        drain();
        check_addrs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
